// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Dot / character / scanline / row counter chain for an Apple-1 style video
//   terminal. It produces the raw counter states plus the sync, blank and load
//   strobes that downstream decode gates combine to drive the shift register,
//   character ROM and cursor logic.
//
// Ports
//   i_clk           system clock
//   i_rst           synchronous reset, active-high, has priority over i_pix_en
//   i_pix_en        dot-clock enable; nothing moves while it is low
//   o_dot           dot index within the character cell
//   o_char_col      character period within the line (visible + blanking)
//   o_scan          scanline within the character row
//   o_char_row      character row, saturates at V_ROWS_VIS during vblank
//   o_hsync         horizontal sync, active-high
//   o_vsync         vertical sync, active-high, whole lines
//   o_blank         high outside the visible character area
//   o_load_char     high while dot==0 in a visible cell
//   o_line_end      high during the last dot of every line
//   o_frame_end     high during the last dot of the last line
//   o_cursor_flash  cursor blink phase
//
// Every output is a flop whose next value is decoded from the next counter
// state, so outputs always agree with the counters of the same cycle and no
// combinational path exists from i_pix_en to any output.
module video_timing_gen #(
  parameter int unsigned DOTS_PER_CHAR = 7,
  parameter int unsigned H_CHARS_VIS   = 40,
  parameter int unsigned H_CHARS_TOTAL = 65,
  parameter int unsigned HSYNC_START   = 48,
  parameter int unsigned HSYNC_LEN     = 4,
  parameter int unsigned SCANS_PER_ROW = 8,
  parameter int unsigned V_ROWS_VIS    = 24,
  parameter int unsigned V_LINES_TOTAL = 262,
  parameter int unsigned VSYNC_START   = 224,
  parameter int unsigned VSYNC_LEN     = 3,
  parameter int unsigned BLINK_FRAMES  = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_en,
  output logic [2:0] o_dot,
  output logic [6:0] o_char_col,
  output logic [2:0] o_scan,
  output logic [4:0] o_char_row,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_blank,
  output logic       o_load_char,
  output logic       o_line_end,
  output logic       o_frame_end,
  output logic       o_cursor_flash
);

  localparam int unsigned FrameW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [2:0]        DotLast   = 3'(DOTS_PER_CHAR - 1);
  localparam logic [6:0]        ColLast   = 7'(H_CHARS_TOTAL - 1);
  localparam logic [6:0]        ColVis    = 7'(H_CHARS_VIS);
  localparam logic [6:0]        HsStart   = 7'(HSYNC_START);
  localparam logic [6:0]        HsEnd     = 7'(HSYNC_START + HSYNC_LEN);
  localparam logic [8:0]        LineLast  = 9'(V_LINES_TOTAL - 1);
  localparam logic [8:0]        LineVis   = 9'(V_ROWS_VIS * SCANS_PER_ROW);
  localparam logic [8:0]        VsStart   = 9'(VSYNC_START);
  localparam logic [8:0]        VsEnd     = 9'(VSYNC_START + VSYNC_LEN);
  localparam logic [2:0]        ScanLast  = 3'(SCANS_PER_ROW - 1);
  localparam logic [4:0]        RowMax    = 5'(V_ROWS_VIS);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

  // Counter state
  logic [2:0]        r_dot;
  logic [6:0]        r_col;
  logic [8:0]        r_line;
  logic [2:0]        r_scan;
  logic [4:0]        r_row;
  logic [FrameW-1:0] r_frame;
  logic              r_flash;

  // Registered decodes
  logic r_hsync, r_vsync, r_blank, r_load, r_line_end, r_frame_end;

  // Next-state values
  logic [2:0]        w_dot_d;
  logic [6:0]        w_col_d;
  logic [8:0]        w_line_d;
  logic [2:0]        w_scan_d;
  logic [4:0]        w_row_d;
  logic [FrameW-1:0] w_frame_d;
  logic              w_flash_d;
  logic              w_dot_wrap, w_col_wrap, w_line_wrap;
  logic              w_hsync_d, w_vsync_d, w_blank_d, w_load_d, w_line_end_d, w_frame_end_d;

  // Wrap conditions cascade: a line wrap implies a char wrap implies a dot wrap.
  always_comb begin
    w_dot_wrap  = (r_dot == DotLast);
    w_col_wrap  = w_dot_wrap && (r_col == ColLast);
    w_line_wrap = w_col_wrap && (r_line == LineLast);
  end

  always_comb begin
    w_dot_d   = r_dot;
    w_col_d   = r_col;
    w_line_d  = r_line;
    w_scan_d  = r_scan;
    w_row_d   = r_row;
    w_frame_d = r_frame;
    w_flash_d = r_flash;

    if (i_pix_en) begin
      w_dot_d = w_dot_wrap ? 3'd0 : r_dot + 3'd1;

      if (w_dot_wrap) begin
        w_col_d = w_col_wrap ? 7'd0 : r_col + 7'd1;
      end

      if (w_col_wrap) begin
        w_line_d = w_line_wrap ? 9'd0 : r_line + 9'd1;
        // The frame length is not a whole number of rows, so scan/row are
        // forced back to the top at frame wrap rather than left to roll over.
        if (w_line_wrap) begin
          w_scan_d = 3'd0;
          w_row_d  = 5'd0;
        end else if (r_scan == ScanLast) begin
          w_scan_d = 3'd0;
          w_row_d  = (r_row == RowMax) ? r_row : r_row + 5'd1;
        end else begin
          w_scan_d = r_scan + 3'd1;
        end
      end

      if (w_line_wrap) begin
        if (r_frame == FrameLast) begin
          w_frame_d = '0;
          w_flash_d = ~r_flash;
        end else begin
          w_frame_d = r_frame + 1'b1;
        end
      end
    end
  end

  // Decode from the next counter state so the registered strobes line up
  // with the registered counters. With i_pix_en low the inputs equal the
  // current state, so every output holds.
  always_comb begin
    w_hsync_d     = (w_col_d >= HsStart) && (w_col_d < HsEnd);
    w_vsync_d     = (w_line_d >= VsStart) && (w_line_d < VsEnd);
    w_blank_d     = (w_col_d >= ColVis) || (w_line_d >= LineVis);
    w_load_d      = !w_blank_d && (w_dot_d == 3'd0);
    w_line_end_d  = (w_dot_d == DotLast) && (w_col_d == ColLast);
    w_frame_end_d = w_line_end_d && (w_line_d == LineLast);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dot       <= 3'd0;
      r_col       <= 7'd0;
      r_line      <= 9'd0;
      r_scan      <= 3'd0;
      r_row       <= 5'd0;
      r_frame     <= '0;
      r_flash     <= 1'b0;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_blank     <= 1'b0;
      r_load      <= 1'b1;  // position (0,0) is visible
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_dot       <= w_dot_d;
      r_col       <= w_col_d;
      r_line      <= w_line_d;
      r_scan      <= w_scan_d;
      r_row       <= w_row_d;
      r_frame     <= w_frame_d;
      r_flash     <= w_flash_d;
      r_hsync     <= w_hsync_d;
      r_vsync     <= w_vsync_d;
      r_blank     <= w_blank_d;
      r_load      <= w_load_d;
      r_line_end  <= w_line_end_d;
      r_frame_end <= w_frame_end_d;
    end
  end

  assign o_dot          = r_dot;
  assign o_char_col     = r_col;
  assign o_scan         = r_scan;
  assign o_char_row     = r_row;
  assign o_hsync        = r_hsync;
  assign o_vsync        = r_vsync;
  assign o_blank        = r_blank;
  assign o_load_char    = r_load;
  assign o_line_end     = r_line_end;
  assign o_frame_end    = r_frame_end;
  assign o_cursor_flash = r_flash;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Instance A uses the default Apple-1 timing for
// line-level checks; instance B uses a shrunken frame (3 dots, 8 chars,
// 11 lines, blink every 4 frames) so frame, vsync and blink behaviour fit in
// a short run. Expected values are hand-computed per pix_en cycle count k
// since reset. The stimulus pushes expectations into a queue; a monitor
// pops and compares them on the falling edge.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_pix_en, b_rst, b_pix_en;
  logic [2:0] a_dot, b_dot, a_scan, b_scan;
  logic [6:0] a_col, b_col;
  logic [4:0] a_row, b_row;
  logic a_hs, a_vs, a_blank, a_load, a_le, a_fe, a_fl;
  logic b_hs, b_vs, b_blank, b_load, b_le, b_fe, b_fl;

  video_timing_gen u_dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_pix_en(a_pix_en),
    .o_dot(a_dot), .o_char_col(a_col), .o_scan(a_scan), .o_char_row(a_row),
    .o_hsync(a_hs), .o_vsync(a_vs), .o_blank(a_blank), .o_load_char(a_load),
    .o_line_end(a_le), .o_frame_end(a_fe), .o_cursor_flash(a_fl)
  );

  video_timing_gen #(
    .DOTS_PER_CHAR(3), .H_CHARS_VIS(4), .H_CHARS_TOTAL(8), .HSYNC_START(5),
    .HSYNC_LEN(2), .SCANS_PER_ROW(2), .V_ROWS_VIS(3), .V_LINES_TOTAL(11),
    .VSYNC_START(7), .VSYNC_LEN(2), .BLINK_FRAMES(4)
  ) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_pix_en(b_pix_en),
    .o_dot(b_dot), .o_char_col(b_col), .o_scan(b_scan), .o_char_row(b_row),
    .o_hsync(b_hs), .o_vsync(b_vs), .o_blank(b_blank), .o_load_char(b_load),
    .o_line_end(b_le), .o_frame_end(b_fe), .o_cursor_flash(b_fl)
  );

  // Signal selectors; instance B adds 16.
  localparam int SDot = 0, SCol = 1, SScan = 2, SRow = 3, SHs = 4, SVs = 5;
  localparam int SBlank = 6, SLoad = 7, SLe = 8, SFe = 9, SFl = 10, B = 16;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } item_t;

  item_t q[$];
  int n_run = 0;
  int n_fail = 0;
  int ka = 0;
  int kb = 0;

  function automatic logic [15:0] get_act(int sel);
    case (sel)
      SDot:       return 16'(a_dot);
      SCol:       return 16'(a_col);
      SScan:      return 16'(a_scan);
      SRow:       return 16'(a_row);
      SHs:        return 16'(a_hs);
      SVs:        return 16'(a_vs);
      SBlank:     return 16'(a_blank);
      SLoad:      return 16'(a_load);
      SLe:        return 16'(a_le);
      SFe:        return 16'(a_fe);
      SFl:        return 16'(a_fl);
      B + SDot:   return 16'(b_dot);
      B + SCol:   return 16'(b_col);
      B + SScan:  return 16'(b_scan);
      B + SRow:   return 16'(b_row);
      B + SHs:    return 16'(b_hs);
      B + SVs:    return 16'(b_vs);
      B + SBlank: return 16'(b_blank);
      B + SLoad:  return 16'(b_load);
      B + SLe:    return 16'(b_le);
      B + SFe:    return 16'(b_fe);
      B + SFl:    return 16'(b_fl);
      default:    return 16'hxxxx;
    endcase
  endfunction

  // Monitor: compare every pending expectation while outputs are stable.
  initial begin
    item_t it;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        it  = q.pop_front();
        act = get_act(it.sel);
        n_run++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %0d, expected %0d", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic push(input string name, input int sel, input int exp);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = 16'(exp);
    q.push_back(it);
  endtask

  task automatic push_all(input string tag, input int off, input int dot, input int col,
                          input int scan, input int row, input int hs, input int vs,
                          input int blank, input int load, input int le, input int fe,
                          input int fl);
    push({tag, ".dot"},   off + SDot,   dot);
    push({tag, ".col"},   off + SCol,   col);
    push({tag, ".scan"},  off + SScan,  scan);
    push({tag, ".row"},   off + SRow,   row);
    push({tag, ".hsync"}, off + SHs,    hs);
    push({tag, ".vsync"}, off + SVs,    vs);
    push({tag, ".blank"}, off + SBlank, blank);
    push({tag, ".load"},  off + SLoad,  load);
    push({tag, ".lend"},  off + SLe,    le);
    push({tag, ".fend"},  off + SFe,    fe);
    push({tag, ".flash"}, off + SFl,    fl);
  endtask

  task automatic adv_a(input int target);
    while (ka < target) begin
      a_pix_en = 1'b1;
      @(posedge clk);
      #1;
      ka++;
    end
    a_pix_en = 1'b0;
  endtask

  task automatic adv_b(input int target);
    while (kb < target) begin
      b_pix_en = 1'b1;
      @(posedge clk);
      #1;
      kb++;
    end
    b_pix_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; a_pix_en = 1'b0; b_pix_en = 1'b0;
    @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    push_all("a_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    push_all("b_rst", B, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // ---- Instance A: default timing, line length 455 ----
    adv_a(7);
    push("a7.dot", SDot, 0); push("a7.col", SCol, 1);
    push("a7.load", SLoad, 1); push("a7.blank", SBlank, 0);
    adv_a(8);
    push("a8.dot", SDot, 1); push("a8.load", SLoad, 0);
    adv_a(279);
    push("a279.blank", SBlank, 0); push("a279.col", SCol, 39);
    adv_a(280);
    push("a280.blank", SBlank, 1); push("a280.col", SCol, 40); push("a280.load", SLoad, 0);
    adv_a(335);
    push("a335.hs", SHs, 0); push("a335.col", SCol, 47); push("a335.dot", SDot, 6);
    adv_a(336);
    push("a336.hs", SHs, 1); push("a336.col", SCol, 48); push("a336.dot", SDot, 0);
    adv_a(363);
    push("a363.hs", SHs, 1); push("a363.col", SCol, 51); push("a363.dot", SDot, 6);
    adv_a(364);
    push("a364.hs", SHs, 0); push("a364.col", SCol, 52);
    adv_a(453);
    push("a453.lend", SLe, 0);
    adv_a(454);
    push("a454.lend", SLe, 1); push("a454.col", SCol, 64); push("a454.dot", SDot, 6);
    push("a454.fend", SFe, 0); push("a454.blank", SBlank, 1);
    adv_a(455);
    push_all("a455", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    adv_a(908);
    push("a908.lend", SLe, 0);
    adv_a(909);
    push("a909.lend", SLe, 1); push("a909.scan", SScan, 1);
    adv_a(910);
    push("a910.lend", SLe, 0); push("a910.scan", SScan, 2);
    adv_a(3639);
    push("a3639.scan", SScan, 7); push("a3639.row", SRow, 0); push("a3639.lend", SLe, 1);
    adv_a(3640);
    push("a3640.scan", SScan, 0); push("a3640.row", SRow, 1);
    adv_a(3740);
    push_all("a_prehold", 0, 2, 14, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    a_pix_en = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    push_all("a_hold", 0, 2, 14, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    adv_a(3741);
    push("a3741.dot", SDot, 3); push("a3741.col", SCol, 14);

    // ---- Instance B: 3 dots x 8 chars = 24 per line, 11 lines = 264 per frame ----
    adv_b(120);
    push("b120.blank", B + SBlank, 0); push("b120.row", B + SRow, 2);
    push("b120.scan", B + SScan, 1); push("b120.load", B + SLoad, 1);
    adv_b(143);
    push("b143.blank", B + SBlank, 1); push("b143.lend", B + SLe, 1);
    adv_b(144);
    push("b144.blank", B + SBlank, 1); push("b144.row", B + SRow, 3);
    push("b144.scan", B + SScan, 0); push("b144.load", B + SLoad, 0);
    adv_b(167);
    push("b167.vs", B + SVs, 0);
    adv_b(168);
    push("b168.vs", B + SVs, 1); push("b168.row", B + SRow, 3); push("b168.scan", B + SScan, 1);
    adv_b(191);
    push("b191.vs", B + SVs, 1);
    adv_b(215);
    push("b215.vs", B + SVs, 1); push("b215.lend", B + SLe, 1); push("b215.fend", B + SFe, 0);
    adv_b(216);
    push("b216.vs", B + SVs, 0); push("b216.scan", B + SScan, 1);
    adv_b(240);
    push("b240.scan", B + SScan, 0); push("b240.row", B + SRow, 3);
    push("b240.blank", B + SBlank, 1);
    adv_b(262);
    push("b262.fend", B + SFe, 0);
    adv_b(263);
    push("b263.fend", B + SFe, 1); push("b263.lend", B + SLe, 1);
    push("b263.scan", B + SScan, 0); push("b263.row", B + SRow, 3);
    push("b263.dot", B + SDot, 2); push("b263.col", B + SCol, 7);
    adv_b(264);
    push_all("b264", B, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    adv_b(279);
    push("b279.hs", B + SHs, 1); push("b279.col", B + SCol, 5);
    adv_b(1055);
    push("b1055.flash", B + SFl, 0); push("b1055.fend", B + SFe, 1);
    adv_b(1056);
    push("b1056.flash", B + SFl, 1); push("b1056.load", B + SLoad, 1);
    adv_b(1159);
    push("b1159.row", B + SRow, 2); push("b1159.col", B + SCol, 2);
    push("b1159.dot", B + SDot, 1); push("b1159.flash", B + SFl, 1);

    // Mid-frame reset with pix_en high: reset must win.
    b_rst = 1'b1; b_pix_en = 1'b1;
    @(posedge clk);
    #1;
    push_all("b_rstmid", B, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    push("b_rst2.dot", B + SDot, 0); push("b_rst2.col", B + SCol, 0);
    b_rst = 1'b0; b_pix_en = 1'b0;
    kb = 0;
    adv_b(263);
    push("b2_263.fend", B + SFe, 1); push("b2_263.flash", B + SFl, 0);
    adv_b(1055);
    push("b2_1055.flash", B + SFl, 0);
    adv_b(1056);
    push("b2_1056.flash", B + SFl, 1);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
